uart_rx_ctrl: RTL

- Receive control and data path for the UART receiver. Sits directly around the bit/packet timer.
- Detects the start bit on the raw serial line and drives enable_timer for the timer.
- Consumes the timer's shift_enable and packet_done pulses to shift in data and stop bits, check the stop bit, and load the received byte into an output buffer.
- Reports data_ready, overrun_error and framing_error to the host side.

---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/uart_rx_ctrl_start_bit_det.sv | 29 ++
 rtl/uart_rx_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RECEIVE,
        CHECK,
        LOAD
    } rx_state_t;

    localparam int DATA_BITS_DEFAULT = 8;
    localparam int FRAME_SHIFTS      = DATA_BITS_DEFAULT + 1;

endpackage

// File: rtl/uart_rx_ctrl_start_bit_det.sv
// Two-flop synchronizer for the raw serial line plus falling-edge (start bit) detect.
module start_bit_det (
    input  logic clk,
    input  logic n_rst,
    input  logic serial_in,
    output logic sync_out,
    output logic start_edge
);

    logic sync_1;
    logic sync_2;
    logic prev;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            prev   <= 1'b1;
        end else begin
            sync_1 <= serial_in;
            sync_2 <= sync_1;
            prev   <= sync_2;
        end
    end

    assign sync_out   = sync_2;
    assign start_edge = prev & ~sync_2;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, timer enable, bit shifting, stop check and output buffer.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 shift_enable,
    input  logic                 packet_done,
    input  logic                 data_read,
    output logic                 enable_timer,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error
);

    rx_state_t          state;
    rx_state_t          next_state;
    logic [DATA_BITS:0] sr;
    logic               sync;
    logic               start_edge;

    start_bit_det u_start_bit_det (
        .clk       (clk),
        .n_rst     (n_rst),
        .serial_in (serial_in),
        .sync_out  (sync),
        .start_edge(start_edge)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state         <= IDLE;
            sr            <= '1;
            rx_data       <= '0;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state <= next_state;

            // Host acknowledge applies everywhere except LOAD, where the new byte wins.
            if (state != LOAD && data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end

            case (state)
                CLEAR: begin
                    framing_error <= 1'b0;
                    sr            <= '1;
                end
                RECEIVE: begin
                    if (shift_enable)
                        sr <= {sync, sr[DATA_BITS:1]};
                end
                CHECK: begin
                    if (!sr[DATA_BITS])
                        framing_error <= 1'b1;
                end
                LOAD: begin
                    rx_data    <= sr[DATA_BITS-1:0];
                    data_ready <= 1'b1;
                    if (data_read)
                        overrun_error <= 1'b0;
                    else if (data_ready)
                        overrun_error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_edge) next_state = CLEAR;
            CLEAR:   next_state = RECEIVE;
            RECEIVE: if (packet_done) next_state = CHECK;
            CHECK:   next_state = sr[DATA_BITS] ? LOAD : IDLE;
            LOAD:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign enable_timer = (state == RECEIVE);

endmodule
